tmr_pipe_reg: RTL and testbench
===============================

Name: tmr_pipe_reg

Overview:
- Parametrised triple-modular-redundant pipeline register for single-event-upset hardening of datapaths.
- Each of STAGES stages holds three copies of WIDTH data bits plus a valid bit. Each stage loads the bitwise majority vote of the previous stage.
- Idle stages optionally self-scrub from their own vote.
- Reports copy disagreement per stage and in aggregate, with a saturating error counter.
- Provides a fault-injection port so benches can flip chosen bits without forcing internal nets.

Parameters:
WIDTH, 8, data bits per copy
STAGES, 2, pipeline depth (>=1); latency in enabled cycles
CNT_W, 8, width of saturating mismatch counter
SCRUB, 1, 1: stage reloads its own vote when en=0; 0: plain hold when en=0

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  data presented to stage 0
in_valid  input  1  qualifies in_data
en  input  1  pipeline advance enable (all stages move together)
inj_en  input  1  apply injection this cycle
inj_stage  input  max(1,$clog2(STAGES))  target stage index
inj_copy  input  2  target copy 0..2 (3 = no effect)
inj_mask  input  WIDTH+1  XOR mask; bit WIDTH hits valid, bits WIDTH-1:0 hit data
out_data  output  WIDTH  bitwise majority of final-stage copies
out_valid  output  1  majority of final-stage valid copies
err_now  output  1  any stage has a disagreement this cycle
err_stage  output  STAGES  sticky per-stage mismatch flags
err_cnt  output  CNT_W  saturating count of cycles with err_now=1
err_clr  input  1  clears err_stage and err_cnt

Behaviour:
- Reset (async, rst=1):
  - All copies (data and valid) of all stages go to 0.
  - err_stage=0 and err_cnt=0.
  - Outputs therefore read out_data=0, out_valid=0, err_now=0.
  - Reset asserted mid-stream discards all in-flight data immediately.
- Next-value source per stage k, per copy c:
  - en=1: stage 0 loads {in_valid,in_data}; stage k>0 loads vote(stage k-1).
  - en=0, SCRUB=1: loads vote(stage k), which repairs a single corrupted copy in one cycle.
  - en=0, SCRUB=0: holds the current copy value.
- Injection:
  - When inj_en=1 and inj_stage=k and inj_copy=c<3, the next value of copy c of stage k is XORed with inj_mask.
  - inj_stage >= STAGES or inj_copy=3 has no effect.
  - Injection combines with any en/scrub source.
- Vote: bitwise majority (a&b)|(b&c)|(a&c), applied to data and valid alike. out_data and out_valid are combinational votes of the final-stage registers.
- Latency: a word accepted at an en=1 edge appears at out after STAGES en=1 edges. With en held high, latency is STAGES clocks.
- Mismatch m[k]: 1 when the three registered copies of stage k are not all identical in any data or valid bit (combinational). err_now = OR of m[k].
- err_stage[k]:
  - Set on any edge where m[k]=1.
  - err_clr=1 clears it.
  - Set takes priority when err_clr and m[k] occur in the same cycle.
- err_cnt:
  - Increments by 1 on each edge where err_now=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - err_clr=1 with err_now=0 clears it to 0; err_clr=1 with err_now=1 loads 1.
- Single-copy upset in stage k is masked at the output. Next-stage copies all load the corrected vote, so the fault never propagates.
- Double upset in the same bit of one stage propagates a wrong value, and m[k] flags it only while copies differ.

Test Plan:
- Reset then en=1, in_valid=1, in_data 0x01,0x02,0x03 on successive cycles -> out_valid=1 and out_data=0x01,0x02,0x03 starting 2 cycles later; err_now=0 and err_cnt=0 throughout.
- en=1, stream 0xA5, inject inj_stage=0, inj_copy=1, inj_mask=0x0FF on the load of 0xA5 -> m[0]=1 for one cycle; out_data=0xA5 two cycles later; err_stage=2'b01; err_cnt=1.
- SCRUB=1, en=0 holding 0x3C, inject stage 1 copy 2 mask 0x001 -> err_now=1 for exactly one cycle, then copies repaired; out_data stays 0x3C; err_cnt=1. Repeat with SCRUB=0 -> err_now stays 1 and err_cnt increments every cycle until reset.
- CNT_W=2, SCRUB=0, persistent stage-1 mismatch for 6 cycles -> err_cnt reads 1,2,3,3,3; then err_clr=1 while mismatch persists -> err_cnt=1 and err_stage[1]=1.
- Double upset: inject copies 0 and 1 of stage 0 with mask 0x100 (valid) when in_valid=0 -> out_valid=1 falsely two cycles later; err_stage[0]=1; m[1]=0.
- Assert rst mid-stream with data in both stages -> out_data=0, out_valid=0, err_stage=0, err_cnt=0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/tmr_pipe_reg.sv
// Triple-modular-redundant pipeline register: each stage keeps three copies of
// {valid,data}, loads the majority vote of its predecessor and reports copy disagreement.
module tmr_pipe_reg #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned SCRUB  = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [WIDTH-1:0]                               in_data,
  input  logic                                           in_valid,
  input  logic                                           en,
  input  logic                                           inj_en,
  input  logic [((STAGES > 1) ? $clog2(STAGES) : 1)-1:0] inj_stage,
  input  logic [1:0]                                     inj_copy,
  input  logic [WIDTH:0]                                 inj_mask,
  output logic [WIDTH-1:0]                               out_data,
  output logic                                           out_valid,
  output logic                                           err_now,
  output logic [STAGES-1:0]                              err_stage,
  output logic [CNT_W-1:0]                               err_cnt,
  input  logic                                           err_clr
);

  localparam int unsigned SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int unsigned DW = WIDTH + 1;

  logic [DW-1:0]     w_vote [STAGES];
  logic [STAGES-1:0] w_mis;
  logic              w_err_now;
  logic [STAGES-1:0] r_err_stage;
  logic [CNT_W-1:0]  r_err_cnt;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [DW-1:0] r_cp  [3];
    logic [DW-1:0] w_nxt [3];
    logic [DW-1:0] w_src;

    if (k == 0) begin : g_head
      assign w_src = {in_valid, in_data};
    end else begin : g_body
      assign w_src = w_vote[k-1];
    end

    assign w_vote[k] = (r_cp[0] & r_cp[1]) | (r_cp[1] & r_cp[2]) | (r_cp[0] & r_cp[2]);
    assign w_mis[k]  = (r_cp[0] != r_cp[1]) || (r_cp[1] != r_cp[2]);

    // Injection is XORed on top of whichever source (advance, scrub, hold) is selected.
    always_comb begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (en) begin
          w_nxt[c] = w_src;
        end else if (SCRUB != 0) begin
          w_nxt[c] = w_vote[k];
        end else begin
          w_nxt[c] = r_cp[c];
        end
        if (inj_en && (inj_stage == SW'(k)) && (inj_copy == 2'(c))) begin
          w_nxt[c] = w_nxt[c] ^ inj_mask;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned c = 0; c < 3; c++) begin
          r_cp[c] <= '0;
        end
      end else begin
        for (int unsigned c = 0; c < 3; c++) begin
          r_cp[c] <= w_nxt[c];
        end
      end
    end
  end

  assign w_err_now = |w_mis;

  // Set beats clear for the sticky flags; a clear during an active mismatch restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_stage <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_stage <= err_clr ? w_mis : (r_err_stage | w_mis);
      if (err_clr) begin
        r_err_cnt <= w_err_now ? CNT_W'(1) : '0;
      end else if (w_err_now && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign out_data  = w_vote[STAGES-1][WIDTH-1:0];
  assign out_valid = w_vote[STAGES-1][WIDTH];
  assign err_now   = w_err_now;
  assign err_stage = r_err_stage;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tmr_pipe_reg.sv
// Directed bench for tmr_pipe_reg: a scrubbing instance (CNT_W=8) and a holding
// instance (SCRUB=0, CNT_W=2) share one stimulus set and are checked against hand values.
module tb_tmr_pipe_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       en;
  logic       inj_en;
  logic [0:0] inj_stage;
  logic [1:0] inj_copy;
  logic [8:0] inj_mask;
  logic       err_clr;

  logic [7:0] a_out_data, b_out_data;
  logic       a_out_valid, b_out_valid;
  logic       a_err_now, b_err_now;
  logic [1:0] a_err_stage, b_err_stage;
  logic [7:0] a_err_cnt;
  logic [1:0] b_err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tmr_pipe_reg #(.WIDTH(8), .STAGES(2), .CNT_W(8), .SCRUB(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .en(en),
    .inj_en(inj_en), .inj_stage(inj_stage), .inj_copy(inj_copy), .inj_mask(inj_mask),
    .out_data(a_out_data), .out_valid(a_out_valid), .err_now(a_err_now),
    .err_stage(a_err_stage), .err_cnt(a_err_cnt), .err_clr(err_clr)
  );

  tmr_pipe_reg #(.WIDTH(8), .STAGES(2), .CNT_W(2), .SCRUB(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .en(en),
    .inj_en(inj_en), .inj_stage(inj_stage), .inj_copy(inj_copy), .inj_mask(inj_mask),
    .out_data(b_out_data), .out_valid(b_out_valid), .err_now(b_err_now),
    .err_stage(b_err_stage), .err_cnt(b_err_cnt), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inject(input logic stg, input logic [1:0] cp, input logic [8:0] m);
    inj_en = 1'b1; inj_stage = stg; inj_copy = cp; inj_mask = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; en = 1'b0;
    inj_en = 1'b0; inj_stage = '0; inj_copy = 2'd3; inj_mask = '0; err_clr = 1'b0;
    #3;
    check("rst_data",  32'(a_out_data),  32'h0);
    check("rst_valid", 32'(a_out_valid), 32'h0);
    check("rst_errnow",32'(a_err_now),   32'h0);
    check("rst_cnt",   32'(a_err_cnt),   32'h0);
    rst = 1'b0;

    // Plain streaming, latency of two enabled edges
    en = 1'b1; in_valid = 1'b1; in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    check("stream_d1", 32'(a_out_data),  32'h01);
    check("stream_v1", 32'(a_out_valid), 32'h1);
    in_data = 8'h03; tick();
    check("stream_d2", 32'(a_out_data),  32'h02);
    tick();
    check("stream_d3", 32'(a_out_data),  32'h03);
    check("stream_errnow", 32'(a_err_now), 32'h0);
    check("stream_cnt",    32'(a_err_cnt), 32'h0);

    // Single upset on the stage-0 load is masked downstream
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_data = 8'hA5; inject(1'b0, 2'd1, 9'h0FF);
    tick();
    inj_en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    check("su_errnow", 32'(a_err_now), 32'h1);
    tick();
    check("su_data",   32'(a_out_data),  32'hA5);
    check("su_valid",  32'(a_out_valid), 32'h1);
    check("su_errnow0",32'(a_err_now),   32'h0);
    check("su_stage",  32'(a_err_stage), 32'h1);
    check("su_cnt",    32'(a_err_cnt),   32'h1);

    // Idle upset: scrubbing instance repairs in one cycle, holding one keeps mismatch
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_data = 8'h3C; tick(); tick();
    en = 1'b0; inject(1'b1, 2'd2, 9'h001); tick();
    inj_en = 1'b0;
    check("scr_a_now1", 32'(a_err_now),  32'h1);
    check("scr_b_now1", 32'(b_err_now),  32'h1);
    check("scr_a_data", 32'(a_out_data), 32'h3C);
    check("scr_b_data", 32'(b_out_data), 32'h3C);
    tick();
    check("scr_a_now2", 32'(a_err_now),  32'h0);
    check("scr_a_cnt",  32'(a_err_cnt),  32'h1);
    check("scr_a_stg",  32'(a_err_stage),32'h2);
    check("scr_b_now2", 32'(b_err_now),  32'h1);
    check("sat_b_c1",   32'(b_err_cnt),  32'h1);
    tick();
    check("sat_b_c2",   32'(b_err_cnt),  32'h2);
    check("scr_a_data2",32'(a_out_data), 32'h3C);
    tick();
    check("sat_b_c3",   32'(b_err_cnt),  32'h3);
    tick();
    check("sat_b_c4",   32'(b_err_cnt),  32'h3);
    tick();
    check("sat_b_c5",   32'(b_err_cnt),  32'h3);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_b_cnt",  32'(b_err_cnt),  32'h1);
    check("clr_b_stg1", 32'(b_err_stage[1]), 32'h1);
    check("clr_a_cnt",  32'(a_err_cnt),  32'h0);
    check("clr_a_stg",  32'(a_err_stage),32'h0);

    // Double upset on stage-0 valid bit (built up while holding) leaks through
    do_reset();
    en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    inject(1'b0, 2'd0, 9'h100); tick();
    inject(1'b0, 2'd1, 9'h100); tick();
    inj_en = 1'b0; en = 1'b1; tick();
    check("du_b_valid", 32'(b_out_valid), 32'h1);
    check("du_b_stg",   32'(b_err_stage), 32'h1);
    check("du_b_now",   32'(b_err_now),   32'h0);
    check("du_a_valid", 32'(a_out_valid), 32'h0);

    // Asynchronous reset with both stages loaded
    do_reset();
    en = 1'b1; in_valid = 1'b1; in_data = 8'h55; inject(1'b0, 2'd0, 9'h001); tick();
    inj_en = 1'b0; in_data = 8'h66; tick();
    check("ar_pre_data", 32'(a_out_data), 32'h55);
    check("ar_pre_cnt",  32'(a_err_cnt),  32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_data",  32'(a_out_data),  32'h0);
    check("ar_valid", 32'(a_out_valid), 32'h0);
    check("ar_stg",   32'(a_err_stage), 32'h0);
    check("ar_cnt",   32'(a_err_cnt),   32'h0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
